// File: rtl/frame_loader_pkg.sv
// Shared types and geometry helpers for the frame loader slice.
// Bank size and address width are derived from the panel dimensions here.
package frame_loader_pkg;

    typedef enum logic [1:0] {
        S_SYNC,
        S_HI,
        S_LO,
        S_GO
    } fl_state_e;

    function automatic int unsigned fl_bank_size(input int unsigned height,
                                                 input int unsigned width);
        return (height * width) / 2;
    endfunction

    function automatic int unsigned fl_addr_w(input int unsigned height,
                                              input int unsigned width);
        int unsigned bs;
        bs = fl_bank_size(height, width);
        return (bs > 1) ? $clog2(bs) : 1;
    endfunction

endpackage

// File: rtl/frame_loader_if.sv
// Byte-stream input and bank write bus of the frame loader.
// AW must match the address width the loader derives from its panel size.
interface frame_loader_if #(
    parameter int unsigned AW = 10
);
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_sof;
    logic          in_ready;
    logic [15:0]   w_data;
    logic [AW-1:0] w_addr;
    logic          bank0_wen;
    logic          bank1_wen;

    modport loader (
        input  in_data, in_valid, in_sof,
        output in_ready, w_data, w_addr, bank0_wen, bank1_wen
    );

    modport source (
        output in_data, in_valid, in_sof,
        input  in_ready, w_data, w_addr, bank0_wen, bank1_wen
    );
endinterface

// File: rtl/frame_loader.sv
// Packs an RGB565 byte stream (high byte first) into 16-bit words and writes
// top-half rows to bank0, bottom-half rows to bank1; pulses go per full frame.
module frame_loader
    import frame_loader_pkg::*;
#(
    parameter int unsigned MATRIX_HEIGHT = 32,
    parameter int unsigned MATRIX_WIDTH  = 64
) (
    input  logic         clk,
    input  logic         rst,
    frame_loader_if.loader bus,
    output logic         go,
    output logic [7:0]   resync_count
);

    localparam int unsigned BANK_SIZE = fl_bank_size(MATRIX_HEIGHT, MATRIX_WIDTH);
    localparam int unsigned AW        = fl_addr_w(MATRIX_HEIGHT, MATRIX_WIDTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(BANK_SIZE - 1);

    fl_state_e     r_state;
    logic [7:0]    r_hi;
    logic [AW-1:0] r_cnt;
    logic          r_bank;
    logic          w_accept;

    assign bus.in_ready = (r_state != S_GO);
    assign w_accept     = bus.in_valid && (r_state != S_GO);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_SYNC;
            r_hi          <= '0;
            r_cnt         <= '0;
            r_bank        <= 1'b0;
            bus.w_data    <= '0;
            bus.w_addr    <= '0;
            bus.bank0_wen <= 1'b0;
            bus.bank1_wen <= 1'b0;
            go            <= 1'b0;
            resync_count  <= '0;
        end else begin
            bus.bank0_wen <= 1'b0;
            bus.bank1_wen <= 1'b0;
            go            <= 1'b0;

            if (r_state == S_GO) begin
                go      <= 1'b1;
                r_state <= S_SYNC;
            end else if (w_accept) begin
                // An SOF byte always restarts the frame; only mid-frame ones count.
                if (bus.in_sof) begin
                    r_hi    <= bus.in_data;
                    r_cnt   <= '0;
                    r_bank  <= 1'b0;
                    r_state <= S_LO;
                    if (r_state != S_SYNC && resync_count != 8'hFF)
                        resync_count <= resync_count + 8'd1;
                end else if (r_state == S_HI) begin
                    r_hi    <= bus.in_data;
                    r_state <= S_LO;
                end else if (r_state == S_LO) begin
                    bus.w_data <= {r_hi, bus.in_data};
                    bus.w_addr <= r_cnt;
                    if (r_bank)
                        bus.bank1_wen <= 1'b1;
                    else
                        bus.bank0_wen <= 1'b1;
                    if (r_cnt == LAST_ADDR) begin
                        r_cnt   <= '0;
                        r_bank  <= 1'b1;
                        r_state <= r_bank ? S_GO : S_HI;
                    end else begin
                        r_cnt   <= r_cnt + AW'(1);
                        r_state <= S_HI;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_frame_loader.sv
// Directed bench for frame_loader on a 4x8 panel (16 words per bank).
// Bank writes are captured into local arrays and compared to computed pixels.
module tb_frame_loader;
    import frame_loader_pkg::*;

    localparam int unsigned H    = 4;
    localparam int unsigned W    = 8;
    localparam int unsigned BANK = 16;
    localparam int unsigned AW   = fl_addr_w(H, W);

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       go;
    logic [7:0] rc;

    frame_loader_if #(.AW(AW)) bus ();

    frame_loader #(
        .MATRIX_HEIGHT(H),
        .MATRIX_WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus),
        .go          (go),
        .resync_count(rc)
    );

    always #5 clk = ~clk;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] m0 [BANK];
    logic [15:0] m1 [BANK];
    int unsigned wen_cnt = 0, go_cnt = 0, rdy_low = 0, both_err = 0, coin_err = 0;
    int unsigned go_cyc = 0, wen_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.bank0_wen) m0[bus.w_addr] = bus.w_data;
            if (bus.bank1_wen) m1[bus.w_addr] = bus.w_data;
            if (bus.bank0_wen || bus.bank1_wen) begin
                wen_cnt++;
                wen_cyc = cyc;
            end
            if (go) begin
                go_cnt++;
                go_cyc = cyc;
            end
            if (bus.bank0_wen && bus.bank1_wen) both_err++;
            if (go && (bus.bank0_wen || bus.bank1_wen)) coin_err++;
            if (!bus.in_ready) rdy_low++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    function automatic logic [31:0] pk(input logic rdy, input logic w0, input logic w1,
                                       input logic g, input logic [15:0] d,
                                       input logic [3:0] a, input logic [7:0] r);
        return {rdy, w0, w1, g, d, a, r};
    endfunction

    function automatic logic [31:0] outs();
        return {bus.in_ready, bus.bank0_wen, bus.bank1_wen, go, bus.w_data, bus.w_addr, rc};
    endfunction

    int unsigned last_acc = 0;

    task automatic send(input logic [7:0] d, input logic s);
        int unsigned guard;
        guard = 0;
        @(negedge clk);
        while (!bus.in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 100) check("send_timeout", 32'd1, 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = s;
        @(posedge clk);
        #1;
        last_acc     = cyc;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
    endtask

    task automatic idle();
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    function automatic logic [15:0] pix(input int unsigned i, input logic [15:0] base);
        logic [15:0] p;
        p = 16'(i * 16'h0821);
        return p ^ base;
    endfunction

    task automatic send_pixels(input int unsigned n, input logic [15:0] base, input bit gaps);
        logic [15:0] p;
        for (int unsigned i = 0; i < n; i++) begin
            p = pix(i, base);
            send(p[15:8], i == 0);
            send(p[7:0], 1'b0);
            if (gaps) idle();
        end
    endtask

    task automatic check_mem(input string tag, input logic [15:0] base);
        int unsigned bad;
        bad = 0;
        for (int unsigned a = 0; a < BANK; a++) begin
            if (m0[a] !== pix(a, base)) bad++;
            if (m1[a] !== pix(a + BANK, base)) bad++;
        end
        check({tag, "_mem_bad_words"}, bad, 0);
        check({tag, "_bank0_1"}, {16'h0, m0[1]}, {16'h0, pix(1, base)});
        check({tag, "_bank1_15"}, {16'h0, m1[15]}, {16'h0, pix(31, base)});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic        v;
        logic        s;
        logic [7:0]  d;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [9];

    int unsigned s_wen, s_go, s_rdy;

    initial begin
        bus.in_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;

        vecs[0] = '{1'b1, 1'b0, 8'hAA, pk(1, 0, 0, 0, 16'h0000, 4'd0, 8'd0)};
        vecs[1] = '{1'b1, 1'b1, 8'h12, pk(1, 0, 0, 0, 16'h0000, 4'd0, 8'd0)};
        vecs[2] = '{1'b0, 1'b0, 8'hFF, pk(1, 0, 0, 0, 16'h0000, 4'd0, 8'd0)};
        vecs[3] = '{1'b1, 1'b0, 8'h34, pk(1, 1, 0, 0, 16'h1234, 4'd0, 8'd0)};
        vecs[4] = '{1'b1, 1'b0, 8'h56, pk(1, 0, 0, 0, 16'h1234, 4'd0, 8'd0)};
        vecs[5] = '{1'b1, 1'b0, 8'h78, pk(1, 1, 0, 0, 16'h5678, 4'd1, 8'd0)};
        vecs[6] = '{1'b0, 1'b1, 8'h11, pk(1, 0, 0, 0, 16'h5678, 4'd1, 8'd0)};
        vecs[7] = '{1'b1, 1'b1, 8'h9A, pk(1, 0, 0, 0, 16'h5678, 4'd1, 8'd1)};
        vecs[8] = '{1'b1, 1'b0, 8'hBC, pk(1, 1, 0, 0, 16'h9ABC, 4'd0, 8'd1)};

        do_reset();
        check("reset_state", outs(), pk(1, 0, 0, 0, 16'h0, 4'd0, 8'd0));

        for (int unsigned i = 0; i < 9; i++) begin
            @(negedge clk);
            bus.in_valid = vecs[i].v;
            bus.in_sof   = vecs[i].s;
            bus.in_data  = vecs[i].d;
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;

        // Test 1: asynchronous reset in the middle of a clock period
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", outs(), pk(1, 0, 0, 0, 16'h0, 4'd0, 8'd0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Test 2: full frame
        s_wen = wen_cnt; s_go = go_cnt; s_rdy = rdy_low;
        send_pixels(32, 16'h0000, 1'b0);
        repeat (4) @(negedge clk);
        check("t2_wen_count", wen_cnt - s_wen, 32);
        check("t2_go_count", go_cnt - s_go, 1);
        check("t2_ready_low_cycles", rdy_low - s_rdy, 1);
        check("t2_last_wen_cycle", wen_cyc, last_acc);
        check("t2_go_cycle", go_cyc, last_acc + 1);
        check_mem("t2", 16'h0000);

        // Test 3: junk bytes before SOF
        s_wen = wen_cnt; s_go = go_cnt;
        send(8'hAA, 1'b0);
        send(8'h55, 1'b0);
        repeat (2) @(negedge clk);
        check("t3_no_wen_before_sof", wen_cnt - s_wen, 0);
        send_pixels(32, 16'h0000, 1'b0);
        repeat (4) @(negedge clk);
        check("t3_go_count", go_cnt - s_go, 1);
        check("t3_wen_count", wen_cnt - s_wen, 32);
        check_mem("t3", 16'h0000);

        // Test 4: partial frame abandoned by a new SOF
        do_reset();
        s_go = go_cnt;
        send_pixels(10, 16'hA5A5, 1'b0);
        send(8'h3C, 1'b0);
        send_pixels(32, 16'h0000, 1'b0);
        repeat (4) @(negedge clk);
        check("t4_resync", {24'h0, rc}, 32'd1);
        check("t4_go_count", go_cnt - s_go, 1);
        check("t4_bank0_0", {16'h0, m0[0]}, 32'h0);
        check_mem("t4", 16'h0000);

        // Test 5: frame with idle cycles interleaved
        send_pixels(4, 16'hFFFF, 1'b0);
        do_reset();
        s_go = go_cnt; s_wen = wen_cnt;
        send_pixels(32, 16'h0000, 1'b1);
        repeat (4) @(negedge clk);
        check("t5_go_count", go_cnt - s_go, 1);
        check("t5_wen_count", wen_cnt - s_wen, 32);
        check_mem("t5", 16'h0000);

        // Test 6: reset mid-frame, then a clean frame, then SOF saturation
        s_go = go_cnt;
        send_pixels(20, 16'h5A5A, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("t6_no_go_partial", go_cnt - s_go, 0);
        check("t6_resync_cleared", {24'h0, rc}, 32'd0);
        send_pixels(32, 16'h0000, 1'b0);
        repeat (4) @(negedge clk);
        check("t6_go_count", go_cnt - s_go, 1);
        check_mem("t6", 16'h0000);

        for (int unsigned i = 0; i < 255; i++) send(8'h01, 1'b1);
        @(negedge clk);
        check("t6_resync_254", {24'h0, rc}, 32'd254);
        for (int unsigned i = 0; i < 46; i++) send(8'h02, 1'b1);
        @(negedge clk);
        check("t6_resync_sat", {24'h0, rc}, 32'd255);

        check("never_both_wens", both_err, 0);
        check("go_never_with_wen", coin_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
